// File: rtl/apb_pkg.sv
// Shared APB definitions for the command-to-APB bridge.
//   APB_ADDR_W / APB_DATA_W : default APB address and data widths
//   apb_state_e             : bridge FSM states
//   apb_cmd_t               : packed command payload (write, addr, wdata)
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB master bridge, one transfer in flight.
// Ports:
//   PCLK, PRESETn                     clock, async active-low reset
//   cmd_valid/cmd_ready               command handshake (cmd_ready decoded from IDLE)
//   cmd_write/cmd_addr/cmd_wdata      command payload
//   rsp_valid/rsp_ready               response handshake
//   rsp_write/rsp_rdata               response payload (rdata is 0 for writes)
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request, registered
//   PRDATA                            APB read data, registered by the slave
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA
);

  apb_state_e        state_q,     state_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic              pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // Writes complete here; reads need one more cycle for the
        // slave's registered PRDATA.
        if (pwrite_q) begin
          state_d     = RESP;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d     = RESP;
        rsp_write_d = 1'b0;
        rsp_rdata_d = PRDATA;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered APB/response strobes follow the state being entered.
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with a behavioural APB register slave.
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;

  int errors = 0;
  int checks = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  // Register slave: commits writes / registers reads at the end of ACCESS.
  logic [31:0] slv_mem [256];
  logic [31:0] slv_rdata;
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < 256; i++) slv_mem[i] <= '0;
      slv_rdata <= '0;
    end else if (PSEL && PENABLE) begin
      if (PWRITE) slv_mem[PADDR] <= PWDATA;
      else        slv_rdata      <= slv_mem[PADDR];
    end
  end
  assign PRDATA = slv_rdata;

  // Reference memory: what each address should read back as.
  logic [31:0] ref_mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask

  // One command, with APB phase checks, latency and response checks.
  // stall > 0 holds rsp_ready low for that many cycles after rsp_valid.
  task automatic run_cmd(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rdata, input int stall, input string tag);
    int k;
    bit got;
    logic [31:0] held;
    @(negedge PCLK);
    rsp_ready = (stall == 0);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge PCLK); k++; end
    if (!cmd_ready) begin
      check({tag, "_accept_timeout"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
    got = 1'b0;
    for (k = 1; k <= 20; k++) begin
      if (k == 1) begin
        check({tag, "_setup_psel_pen"}, {30'd0, PSEL, PENABLE}, 32'b10);
        check({tag, "_setup_paddr"}, 32'(PADDR), 32'(a));
        check({tag, "_setup_pwrite"}, 32'(PWRITE), 32'(w));
        if (w) check({tag, "_setup_pwdata"}, PWDATA, d);
      end else if (k == 2) begin
        check({tag, "_access_psel_pen"}, {30'd0, PSEL, PENABLE}, 32'b11);
      end else if (k == 3 && !w) begin
        check({tag, "_capture_psel_pen"}, {30'd0, PSEL, PENABLE}, 32'b00);
      end
      if (rsp_valid) begin got = 1'b1; break; end
      @(negedge PCLK);
    end
    if (!got) begin
      check({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
      return;
    end
    check({tag, "_latency"}, 32'(k), w ? 32'd3 : 32'd4);
    check({tag, "_rsp_write"}, 32'(rsp_write), 32'(w));
    check({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
    held = rsp_rdata;
    for (int s = 0; s < stall; s++) begin
      @(negedge PCLK);
      check({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_stall_rdata"}, rsp_rdata, held);
      check({tag, "_stall_busy"}, {29'd0, cmd_ready, PSEL, PENABLE}, 32'd0);
      check({tag, "_stall_paddr"}, 32'(PADDR), 32'(a));
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    check({tag, "_rsp_consumed"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
  endtask

  // Command with expected read data taken from the reference memory.
  task automatic model_cmd(input logic w, input logic [7:0] a, input logic [31:0] d,
                           input string tag);
    run_cmd(w, a, d, w ? 32'd0 : ref_mem[a], 0, tag);
    if (w) ref_mem[a] = d;
  endtask

  typedef struct {
    apb_cmd_t    cmd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [8];
  apb_cmd_t    b2b  [8];
  int          acc_cyc [8];
  int          idx, ridx, cyc, k;
  bit          prev_setup;
  logic [31:0] exp_b2b;

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    clear_ref();

    // Reset held for 3 cycles, then idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("rst_apb", {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
      check("rst_paddr_pwdata", {24'd0, PADDR} | PWDATA, 32'd0);
      check("rst_rsp", {30'd0, rsp_valid, rsp_write}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    PRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      check("idle_quiet", {29'd0, PSEL, PENABLE, rsp_valid}, 32'd0);
      check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    end

    // Directed table: write/read and boundary addresses.
    vecs[0] = '{'{1'b1, 8'h10, 32'hDEADBEEF}, 32'h0};
    vecs[1] = '{'{1'b0, 8'h10, 32'h0},        32'hDEADBEEF};
    vecs[2] = '{'{1'b1, 8'h00, 32'h00000001}, 32'h0};
    vecs[3] = '{'{1'b1, 8'hFF, 32'hFFFFFFFF}, 32'h0};
    vecs[4] = '{'{1'b0, 8'h00, 32'h0},        32'h00000001};
    vecs[5] = '{'{1'b0, 8'hFF, 32'h0},        32'hFFFFFFFF};
    vecs[6] = '{'{1'b0, 8'h80, 32'h0},        32'h0};
    vecs[7] = '{'{1'b0, 8'h10, 32'h0},        32'hDEADBEEF};
    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].cmd.write, vecs[i].cmd.addr, vecs[i].cmd.wdata,
              vecs[i].exp_rdata, 0, $sformatf("vec%0d", i));
      if (vecs[i].cmd.write) ref_mem[vecs[i].cmd.addr] = vecs[i].cmd.wdata;
    end

    // Response backpressure: rsp_ready low for 5 cycles.
    run_cmd(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 5, "stall");

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 30; i++) begin
      model_cmd(1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)), $urandom,
                $sformatf("rnd%0d", i));
    end

    // Back-to-back: cmd_valid held high, alternating write/read to 0x20..0x23.
    for (int i = 0; i < 8; i++) begin
      b2b[i].write = (i % 2 == 0);
      b2b[i].addr  = 8'h20 + 8'(i / 2);
      b2b[i].wdata = 32'hC0DE0000 + 32'(i);
    end
    idx = 0; ridx = 0; prev_setup = 1'b0;
    for (cyc = 0; cyc < 200; cyc++) begin
      @(negedge PCLK);
      if (PENABLE) begin
        check("b2b_setup_before_access", 32'(prev_setup), 32'd1);
        check("b2b_access_psel", 32'(PSEL), 32'd1);
      end
      prev_setup = PSEL && !PENABLE;
      if (rsp_valid) begin
        if (ridx < 8) begin
          exp_b2b = b2b[ridx].write ? 32'd0 : b2b[ridx-1].wdata;
          check($sformatf("b2b_rsp%0d_write", ridx), 32'(rsp_write), 32'(b2b[ridx].write));
          check($sformatf("b2b_rsp%0d_rdata", ridx), rsp_rdata, exp_b2b);
        end
        ridx++;
      end
      if (idx < 8) begin
        cmd_valid = 1'b1; cmd_write = b2b[idx].write;
        cmd_addr = b2b[idx].addr; cmd_wdata = b2b[idx].wdata;
        if (cmd_ready) begin acc_cyc[idx] = cyc; idx++; end
      end else begin
        cmd_valid = 1'b0;
      end
      if (idx == 8 && ridx >= 8) break;
    end
    cmd_valid = 1'b0;
    check("b2b_rsp_count", 32'(ridx), 32'd8);
    for (int i = 0; i < 7; i++)
      check($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i+1] - acc_cyc[i]),
            b2b[i].write ? 32'd4 : 32'd5);
    for (int i = 0; i < 8; i++) if (b2b[i].write) ref_mem[b2b[i].addr] = b2b[i].wdata;

    // Reset during ACCESS.
    model_cmd(1'b1, 8'h30, 32'h12345678, "pre_rst_wr");
    model_cmd(1'b0, 8'h30, 32'h0, "pre_rst_rd");
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h31; cmd_wdata = 32'hABCD0001;
    k = 0;
    while (!PENABLE && k < 20) begin
      @(negedge PCLK); k++;
      if (!cmd_ready) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    check("rst_mid_saw_access", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    #1;
    check("rst_mid_apb_drop", {30'd0, PSEL, PENABLE}, 32'd0);
    check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      check("rst_mid_hold", {29'd0, PSEL, PENABLE, rsp_valid}, 32'd0);
    end
    PRESETn = 1'b1;
    clear_ref();
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("rst_after_quiet", {29'd0, PSEL, PENABLE, rsp_valid}, 32'd0);
    end
    model_cmd(1'b0, 8'h30, 32'h0, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Converts a simple valid/ready command stream into APB transfers for the 8-bit-address, 32-bit-data register slave, and returns one response per command. Sits directly upstream of the APB slave and drives its PSEL/PENABLE/PWRITE/PADDR/PWDATA. It samples the slave's registered PRDATA one cycle after the ACCESS phase. One transfer is in flight at a time.

## Interface
Parameters:
- ADDR_W, 8, APB address width
- DATA_W, 32, APB data width

Ports (one clock; reset is asynchronous and active-low):
- PCLK  input  1  clock, all logic on rising edge
- PRESETn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  bridge accepts command this cycle
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_W  target address
- cmd_wdata  input  DATA_W  write data, ignored for reads
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_write  output  1  echo of the command type
- rsp_rdata  output  DATA_W  read data; 0 for writes
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PWRITE  output  1  APB direction
- PADDR  output  ADDR_W  APB address
- PWDATA  output  DATA_W  APB write data
- PRDATA  input  DATA_W  APB read data, registered by the slave

## Operation
- FSM states: IDLE, SETUP, ACCESS, CAPTURE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch the command into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. The slave commits the write or registers the read at the end of this cycle.
  - Write: go to RESP.
  - Read: go to CAPTURE.
- CAPTURE (reads only): PSEL=0, PENABLE=0. Load PRDATA into rsp_rdata at the end of the cycle, then go to RESP.
- RESP: rsp_valid=1, with rsp_write/rsp_rdata stable.
  - On rsp_ready, go to IDLE.
  - Otherwise hold indefinitely.
- Write responses carry rsp_rdata=0.
- cmd_ready is 0 in every state except IDLE. A command presented while busy is not consumed and must be held by the producer.
- The slave has no PREADY and no PSLVERR, so every transfer completes in exactly one ACCESS cycle.
- After a transfer, PADDR/PWDATA/PWRITE keep their last values until the next command is accepted.
- PSEL=0 in IDLE, CAPTURE and RESP.

## Timing
- All outputs are registered except cmd_ready, which is decoded from the IDLE state.
- Reset values:
  - State IDLE.
  - PSEL, PENABLE, PWRITE = 0.
  - PADDR, PWDATA = 0.
  - rsp_valid, rsp_write = 0; rsp_rdata = 0.
  - cmd_ready = 1.
- Write latency: command accepted at edge N → SETUP in cycle N+1, ACCESS in N+2, rsp_valid in N+3.
- Read latency: same as write, plus CAPTURE in N+3 and rsp_valid in N+4.
- Minimum command spacing with rsp_ready held at 1:
  - Writes: 4 cycles (IDLE, SETUP, ACCESS, RESP).
  - Reads: 5 cycles.
- rsp_valid and rsp_ready both high at an edge → the response is consumed and the FSM is in IDLE the next cycle. There is no IDLE→SETUP bypass from RESP.
- Reset mid-transfer (any state): all outputs return to reset values asynchronously and the in-flight command is dropped without a response. PSEL and PENABLE are guaranteed 0 during and after reset.
- Address range: all 2^ADDR_W addresses are legal; there is no wrap or decode.

## Structure
- Shared package apb_pkg holds:
  - APB_ADDR_W=8 and APB_DATA_W=32 constants.
  - typedef enum apb_state_e {IDLE, SETUP, ACCESS, CAPTURE, RESP}.
  - A packed apb_cmd_t struct (write, addr, wdata).
- Single module, no sub-modules. The testbench instantiates apb_master_bridge driving the existing APB slave.

## Test plan
- Reset then idle:
  - PRESETn low for 3 cycles, then released with no commands.
  - Required: PSEL=PENABLE=0, cmd_ready=1, rsp_valid=0 throughout.
- Single write then read:
  - Write 0xDEADBEEF to 0x10, then read 0x10.
  - Required: write rsp_valid 3 cycles after accept, with rsp_rdata=0 and rsp_write=1.
  - Required: read rsp_valid 4 cycles after accept, with rsp_rdata=0xDEADBEEF and rsp_write=0.
- Boundary addresses:
  - Write 0x00000001 to 0x00 and 0xFFFFFFFF to 0xFF.
  - Required: reading back each returns its own value with no aliasing. Reading an unwritten address 0x80 returns 0.
- Response backpressure:
  - Read 0x10 with rsp_ready low for 5 cycles.
  - Required: rsp_valid and rsp_rdata are held stable, cmd_ready=0 and PSEL=0 for the whole stall; one response is delivered on release.
- Back-to-back commands:
  - cmd_valid held high with 4 alternating writes/reads to 0x20–0x23 and rsp_ready=1.
  - Required: exact APB SETUP/ACCESS sequencing, and spacing of 4 cycles (write) and 5 cycles (read).
  - Required: each read returns the value written in the preceding write.
- Reset during ACCESS:
  - Assert PRESETn low while PENABLE=1.
  - Required: PSEL/PENABLE drop to 0 immediately and no response is issued.
  - Required: after release, the next read of a previously written address returns 0 (the slave is reset too).
